// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed hex seven-segment scanner with frame-synchronous update
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_LOG2   = 14,
    parameter int BRIGHT_BITS    = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      blankLeadingZeros,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [6:0]                segments,
    output logic [NUM_DIGITS-1:0]     digitEnable,
    output logic                      frameDone
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [REFRESH_LOG2-1:0]   prescaler;
    logic [IDX_W-1:0]          digit_index;
    logic [4*NUM_DIGITS-1:0]   staging;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic                      pending;

    logic                      terminal;
    logic                      boundary;
    logic [BRIGHT_BITS-1:0]    duty;
    logic [3:0]                cur_nibble;
    logic                      upper_zero;
    logic                      blank_cur;
    logic [NUM_DIGITS-1:0]     onehot;
    logic [6:0]                seg_next;
    logic                      show;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    assign terminal = &prescaler;
    assign boundary = terminal && (digit_index == LAST_IDX);
    assign duty     = prescaler[REFRESH_LOG2-1 -: BRIGHT_BITS];

    // upper_zero: the current digit and every more significant digit are zero
    always_comb begin
        cur_nibble = 4'h0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_index == IDX_W'(i)) begin
                cur_nibble = shadow[4*i +: 4];
                onehot[i]  = 1'b1;
            end
            if ((i >= int'(digit_index)) && (shadow[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blank_cur = blankLeadingZeros && (digit_index != '0) && upper_zero;
    assign seg_next  = blank_cur ? 7'h00 : hex_font(cur_nibble);
    // prescaler==0 is the dead cycle where the segment bus is allowed to change
    assign show      = (prescaler != '0) && (duty <= brightness);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prescaler   <= '0;
            digit_index <= '0;
            staging     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (terminal) begin
                digit_index <= (digit_index == LAST_IDX) ? '0 : digit_index + 1'b1;
            end
            if (load) begin
                staging <= value;
            end
            if (boundary) begin
                shadow  <= load ? value : (pending ? staging : shadow);
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            segments    <= {7{SEG_INV}};
            digitEnable <= {NUM_DIGITS{DIG_INV}};
            frameDone   <= 1'b0;
        end else begin
            segments    <= seg_next ^ {7{SEG_INV}};
            digitEnable <= (show ? onehot : '0) ^ {NUM_DIGITS{DIG_INV}};
            frameDone   <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

    logic        clk;
    logic        rstN;
    logic [15:0] value;
    logic        load;
    logic        blankLeadingZeros;
    logic [1:0]  brightness;
    logic [6:0]  segments;
    logic [3:0]  digitEnable;
    logic        frameDone;

    int checks   = 0;
    int failures = 0;

    seven_segment_scanner #(
        .NUM_DIGITS(4), .REFRESH_LOG2(4), .BRIGHT_BITS(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rstN(rstN), .value(value), .load(load),
        .blankLeadingZeros(blankLeadingZeros), .brightness(brightness),
        .segments(segments), .digitEnable(digitEnable), .frameDone(frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int font [16] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07,
                      32'h7F, 32'h6F, 32'h77, 32'h7C, 32'h39, 32'h5E, 32'h79, 32'h71};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: edge e after reset release sees slot e/16, phase e%16; the shown value is
    // the latest load sampled at or before the most recent frame-end edge (e%64==63).
    int   edges;
    int   shown;
    int   last_load;
    int   exp_seg, exp_en, exp_fd;
    bit   exp_valid;
    int   last_fd;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            edges = 0; shown = 0; last_load = 0; exp_valid = 0; last_fd = -1;
        end else begin
            int pre, d, upper;
            pre   = edges % 16;
            d     = (edges / 16) % 4;
            upper = shown >> (4 * d);
            exp_seg = (blankLeadingZeros && d > 0 && upper == 0) ? 0 : font[upper & 15];
            exp_en  = (pre != 0 && pre / 4 <= int'(brightness)) ? (1 << d) : 0;
            exp_fd  = (edges % 64 == 63) ? 1 : 0;
            if (load) last_load = int'(value);
            if (edges % 64 == 63) shown = last_load;
            edges++;
            exp_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (!rstN) begin
            chk("rst_seg", 32'(segments), 0);
            chk("rst_en", 32'(digitEnable), 0);
            chk("rst_fd", 32'(frameDone), 0);
        end else if (exp_valid) begin
            chk("model_seg", 32'(segments), exp_seg);
            chk("model_en", 32'(digitEnable), exp_en);
            chk("model_fd", 32'(frameDone), exp_fd);
            if (frameDone) begin
                if (last_fd >= 0) chk("fd_period", edges - last_fd, 64);
                last_fd = edges;
            end
        end
    end

    task automatic wait_edges(input int n);
        int guard = 0;
        while (edges < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_edges", edges, n);
    endtask

    task automatic do_load(input int n, input logic [15:0] v);
        wait_edges(n);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic check_at(input int n, input string name, input int s, input int en);
        wait_edges(n + 1);
        chk({name, "_seg"}, 32'(segments), s);
        chk({name, "_en"}, 32'(digitEnable), en);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rstN = 1'b0; load = 1'b0; value = '0; blankLeadingZeros = 1'b0; brightness = 2'd3;
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        // reset release, scan order, frame pulse
        check_at(0, "first_edge", 32'h3F, 0);
        check_at(1, "first_en", 32'h3F, 1);
        do_load(5, 16'h1234);
        wait_edges(64);
        chk("fd_first", 32'(frameDone), 1);
        check_at(72, "f2_d0", 32'h66, 1);
        check_at(88, "f2_d1", 32'h4F, 2);
        check_at(104, "f2_d2", 32'h5B, 4);
        check_at(120, "f2_d3", 32'h06, 8);
        wait_edges(128);
        chk("fd_second", 32'(frameDone), 1);

        // tear-free update and latest-load-wins
        do_load(149, 16'hABCD);
        check_at(168, "old_d2", 32'h5B, 4);
        check_at(184, "old_d3", 32'h06, 8);
        check_at(200, "new_d0", 32'h5E, 1);
        do_load(205, 16'h1111);
        check_at(216, "new_d1", 32'h39, 2);
        check_at(232, "new_d2", 32'h7C, 4);
        do_load(235, 16'h2222);
        check_at(248, "new_d3", 32'h77, 8);
        check_at(264, "latest_d0", 32'h5B, 1);

        // boundary bypass overrides an older pending load
        do_load(270, 16'h0777);
        do_load(319, 16'h00F0);
        check_at(344, "bypass_d1", 32'h71, 2);
        check_at(408, "bypass_keep", 32'h71, 2);

        // leading-zero blanking
        do_load(410, 16'h0050);
        wait_edges(420);
        blankLeadingZeros = 1'b1;
        check_at(456, "lz_d0", 32'h3F, 1);
        do_load(460, 16'h0000);
        check_at(472, "lz_d1", 32'h6D, 2);
        check_at(488, "lz_d2", 32'h00, 4);
        check_at(504, "lz_d3", 32'h00, 8);
        check_at(520, "zero_d0", 32'h3F, 1);
        check_at(552, "zero_d2", 32'h00, 4);
        wait_edges(565);
        blankLeadingZeros = 1'b0;
        check_at(570, "noblank_live", 32'h3F, 8);
        check_at(584, "noblank_d0", 32'h3F, 1);
        check_at(600, "noblank_d1", 32'h3F, 2);

        // brightness duty per slot
        wait_edges(640);
        brightness = 2'd0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) chk("dead_b0", 32'(digitEnable), 0);
            if (digitEnable != 4'd0) cnt++;
        end
        chk("bright0_cnt", cnt, 3);
        brightness = 2'd3;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) chk("dead_b3", 32'(digitEnable), 0);
            if (digitEnable != 4'd0) cnt++;
        end
        chk("bright3_cnt", cnt, 15);

        // asynchronous reset mid-frame with a pending load
        do_load(675, 16'h5678);
        wait_edges(681);
        chk("pre_rst_en", 32'(digitEnable), 4);
        chk("pre_rst_seg", 32'(segments), 32'h3F);
        #2 rstN = 1'b0;
        #1;
        chk("async_seg", 32'(segments), 0);
        chk("async_en", 32'(digitEnable), 0);
        chk("async_fd", 32'(frameDone), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        check_at(0, "post_rst_first", 32'h3F, 0);
        check_at(72, "post_rst_d0", 32'h3F, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
